sdram_write_buffer: RTL and testbench
=====================================

Name: sdram_write_buffer

Overview:
- Client-side adapter that sits directly upstream of one SDRAM controller port and drives that port's request signals.
- Posts client writes into a small FIFO and drains them to the port in order.
- Merges repeated writes to the same word into the newest queued entry.
- Serialises reads behind all queued writes, so read-after-write ordering holds, and returns read data to the client.

Parameters:
- ADDR_WIDTH, 25, word address width (matches the controller port address width).
- DATA_WIDTH, 16, write data width.
- DQM_WIDTH, 2, byte-enable width (DATA_WIDTH/8).
- OUTPUT_WIDTH, 16, read data width (port burst length × DATA_WIDTH).
- DEPTH, 8, FIFO entries; must be a power of two and ≥ 2.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_WIDTH  client word address.
- cpu_data  in  DATA_WIDTH  client write data.
- cpu_byte_en  in  DQM_WIDTH  client byte lanes, 1 = write this lane.
- cpu_wr  in  1  client write request.
- cpu_rd  in  1  client read request.
- cpu_ready  out  1  request accepted this cycle if cpu_wr or cpu_rd is high.
- cpu_q  out  OUTPUT_WIDTH  read data.
- cpu_q_valid  out  1  one-cycle pulse; cpu_q is valid.
- mem_addr  out  ADDR_WIDTH  port address.
- mem_data  out  DATA_WIDTH  port write data.
- mem_byte_en  out  DQM_WIDTH  port byte enables.
- mem_wr  out  1  port write request.
- mem_rd  out  1  port read request.
- mem_busy  in  1  port stall; a request is accepted in any cycle where the request is high and mem_busy is low.
- mem_q  in  OUTPUT_WIDTH  port read data.
- mem_q_valid  in  1  port read data valid.
- fill_level  out  $clog2(DEPTH)+1  queued entries.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Outputs while reset is sampled high and on the following cycle:
  - mem_wr, mem_rd, cpu_q_valid, fill_level = 0; cpu_q = 0.
  - mem_addr, mem_data, mem_byte_en = 0.
  - cpu_ready = 0 during reset; after reset it follows the rule below.
- cpu_ready is combinational: !reset && fill_level != DEPTH && state is S_IDLE or S_WR.
- FIFO: read/write pointers carry a wrap bit. full = count == DEPTH; empty = count == 0.
- Write accept (cpu_wr && cpu_ready):
  - Merge case: tail address == cpu_addr, and the tail is not the head currently presented (count ≥ 2, or state != S_WR). Overwrite only the tail's data lanes enabled by cpu_byte_en and OR the enables into the tail entry; count is unchanged.
  - Otherwise push a new entry.
- cpu_wr and cpu_rd high together: treated as a write only; cpu_rd is ignored that cycle.
- Issue FSM states: S_IDLE, S_WR, S_RD_PEND, S_RD, S_RD_WAIT.
  - S_IDLE, FIFO non-empty → S_WR. mem_wr rises the cycle after the first push (1-cycle latency) and presents the head entry.
  - S_WR: mem_wr, addr, data and byte_en are held stable until accepted. On accept, pop the head.
    - More entries remain: present the next entry the following cycle (back-to-back, mem_wr stays high).
    - FIFO now empty: → S_IDLE, or → S_RD if a read is captured.
  - Read accept (cpu_rd && cpu_ready, no cpu_wr): capture the address.
    - From S_IDLE with the FIFO empty → S_RD.
    - Otherwise → S_RD_PEND; the current write drain continues until the FIFO is empty, then → S_RD.
  - S_RD: mem_rd held with mem_addr until accepted → S_RD_WAIT. mem_data and mem_byte_en are don't-care; drive 0.
  - S_RD_WAIT: on mem_q_valid, register mem_q into cpu_q and pulse cpu_q_valid on the next cycle → S_IDLE.
- One read outstanding at a time. No writes are accepted from capture of a read until its data returns.
- Wrap-around: pointers wrap modulo DEPTH. The wrap bit distinguishes full from empty.
- A push and a pop in the same cycle leave count unchanged. A push into a full FIFO is impossible because cpu_ready is low.
- mem_q_valid outside S_RD_WAIT is ignored.
- Reset mid-operation: queued writes and any pending read are discarded. mem_wr and mem_rd go low at the next edge. No cpu_q_valid is produced for the discarded read.

Decomposition:
- Package sdram_wbuf_pkg holds:
  - state enum wbuf_state_e.
  - typedef wbuf_entry_t {addr, data, byte_en}, parameterised via localparams.
  - function merge_lanes (byte-lane merge).
- Sub-module sdram_wbuf_fifo holds the storage, pointers, count, push/pop and the tail-merge write port.
- The top level holds the FSM and the read path.

Test Plan:
- Reset, mem_busy=0; write 0x10=0x1111, 0x11=0x2222, 0x12=0x3333 on consecutive cycles → mem_wr high for 3 consecutive cycles starting 1 cycle after the first write, addresses in order; fill_level ends at 0.
- mem_busy=1; write 9 distinct addresses back-to-back → cpu_ready low after the 8th accept, fill_level=8. Release mem_busy → 8 writes issued in order, then the 9th is accepted and issued.
- mem_busy=1; write 0x1F; write 0x20 data 0x00AA be=01; write 0x20 data 0xBB00 be=10 → fill_level=2. Release → port sees 0x1F, then 0x20 with data 0xBBAA and be=11.
- Write 0x30=0x1234, then read 0x30 on the next cycle; the model returns the stored data → mem_rd only after mem_wr for 0x30 is accepted; cpu_q_valid pulses with cpu_q=0x1234 one cycle after mem_q_valid.
- mem_busy=1 with 4 writes queued; assert reset for 1 cycle → mem_wr low the next cycle, fill_level=0; no further mem_wr/mem_rd after release.
- cpu_wr and cpu_rd both high, addr 0x40 data 0x5555 → one write of 0x5555 to 0x40; no mem_rd, no cpu_q_valid.

Source files
------------

// File: rtl/sdram_wbuf_pkg.sv
// Shared types and helpers for the SDRAM write buffer.
//   wbuf_state_e : issue FSM states
//   wbuf_entry_t : one queued write (word address, data, byte enables)
//   merge_lanes  : byte-lane merge of new write data over an existing entry
package sdram_wbuf_pkg;

  localparam int WBUF_ADDR_WIDTH = 25;
  localparam int WBUF_DATA_WIDTH = 16;
  localparam int WBUF_DQM_WIDTH  = WBUF_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_PEND,
    S_RD,
    S_RD_WAIT
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_ADDR_WIDTH-1:0] addr;
    logic [WBUF_DATA_WIDTH-1:0] data;
    logic [WBUF_DQM_WIDTH-1:0]  byte_en;
  } wbuf_entry_t;

  function automatic logic [WBUF_DATA_WIDTH-1:0] merge_lanes(
    input logic [WBUF_DATA_WIDTH-1:0] old_data,
    input logic [WBUF_DATA_WIDTH-1:0] new_data,
    input logic [WBUF_DQM_WIDTH-1:0]  byte_en
  );
    logic [WBUF_DATA_WIDTH-1:0] result;
    result = old_data;
    for (int unsigned i = 0; i < WBUF_DQM_WIDTH; i++) begin
      if (byte_en[i]) result[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/sdram_wbuf_fifo.sv
// Write-posting FIFO with a tail-merge write port.
//   push/wr_entry : append a new entry at the tail
//   merge         : fold wr_entry's enabled lanes into the current tail entry
//   pop           : drop the head entry
//   head          : oldest entry, tail_addr : address of newest entry
//   count/full/empty : occupancy (pointers carry a wrap bit)
module sdram_wbuf_fifo
  import sdram_wbuf_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       merge,
  input  logic                       pop,
  input  wbuf_entry_t                wr_entry,
  output wbuf_entry_t                head,
  output logic [WBUF_ADDR_WIDTH-1:0] tail_addr,
  output logic [PTR_W:0]             count,
  output logic                       full,
  output logic                       empty
);

  wbuf_entry_t      mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] tail_idx;

  assign wr_idx    = wr_ptr[PTR_W-1:0];
  assign rd_idx    = rd_ptr[PTR_W-1:0];
  assign tail_idx  = wr_idx - PTR_W'(1);
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_idx];
  assign tail_addr = mem[tail_idx].addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= wr_entry;
        wr_ptr      <= wr_ptr + (PTR_W+1)'(1);
      end
      if (merge) begin
        mem[tail_idx].data    <= merge_lanes(mem[tail_idx].data, wr_entry.data, wr_entry.byte_en);
        mem[tail_idx].byte_en <= mem[tail_idx].byte_en | wr_entry.byte_en;
      end
      if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/sdram_write_buffer.sv
// Client-side write buffer in front of one SDRAM controller port.
// Client side: cpu_addr/cpu_data/cpu_byte_en with cpu_wr/cpu_rd, accepted
// when cpu_ready; read data returns on cpu_q with a one-cycle cpu_q_valid.
// Port side: mem_addr/mem_data/mem_byte_en with mem_wr/mem_rd, accepted when
// mem_busy is low; read data arrives on mem_q/mem_q_valid.
// Writes are posted and drained in order, repeated writes to the newest
// queued word are merged, and a read waits until all queued writes drain.
// fill_level reports the number of queued entries.
module sdram_write_buffer
  import sdram_wbuf_pkg::*;
#(
  parameter int ADDR_WIDTH   = WBUF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = WBUF_DATA_WIDTH,
  parameter int DQM_WIDTH    = WBUF_DQM_WIDTH,
  parameter int OUTPUT_WIDTH = 16,
  parameter int DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      cpu_addr,
  input  logic [DATA_WIDTH-1:0]      cpu_data,
  input  logic [DQM_WIDTH-1:0]       cpu_byte_en,
  input  logic                       cpu_wr,
  input  logic                       cpu_rd,
  output logic                       cpu_ready,
  output logic [OUTPUT_WIDTH-1:0]    cpu_q,
  output logic                       cpu_q_valid,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic [DQM_WIDTH-1:0]       mem_byte_en,
  output logic                       mem_wr,
  output logic                       mem_rd,
  input  logic                       mem_busy,
  input  logic [OUTPUT_WIDTH-1:0]    mem_q,
  input  logic                       mem_q_valid,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  wbuf_state_e           state;
  wbuf_state_e           state_next;
  wbuf_entry_t           in_entry;
  wbuf_entry_t           head;
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic wr_acc;
  logic rd_acc;
  logic merge_hit;
  logic push;
  logic merge;
  logic issue_wr;
  logic pop;
  logic last_pop;

  assign in_entry.addr    = cpu_addr;
  assign in_entry.data    = cpu_data;
  assign in_entry.byte_en = cpu_byte_en;

  sdram_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .merge     (merge),
    .pop       (pop),
    .wr_entry  (in_entry),
    .head      (head),
    .tail_addr (tail_addr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign cpu_ready = !reset && !full && (state == S_IDLE || state == S_WR);
  assign wr_acc    = cpu_wr && cpu_ready;
  assign rd_acc    = cpu_rd && !cpu_wr && cpu_ready;

  // With a single entry in S_WR the tail is the head on the port and must
  // stay stable, so a same-address write is queued instead of merged.
  assign merge_hit = !empty && (tail_addr == cpu_addr) &&
                     (count >= CNT_TWO || state != S_WR);
  assign push      = wr_acc && !merge_hit;
  assign merge     = wr_acc && merge_hit;

  // Writes drain in S_WR and also while a captured read waits in S_RD_PEND.
  assign issue_wr  = (state == S_WR || state == S_RD_PEND) && !empty;
  assign pop       = issue_wr && !mem_busy;
  assign last_pop  = pop && (count == CNT_ONE) && !push;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!empty)      state_next = rd_acc ? S_RD_PEND : S_WR;
        else if (wr_acc) state_next = S_WR;
        else if (rd_acc) state_next = S_RD;
      end
      S_WR: begin
        if (rd_acc)        state_next = last_pop ? S_RD : S_RD_PEND;
        else if (last_pop) state_next = S_IDLE;
      end
      S_RD_PEND: begin
        if (last_pop || empty) state_next = S_RD;
      end
      S_RD: begin
        if (!mem_busy) state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_q_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr      = issue_wr;
    mem_rd      = (state == S_RD);
    mem_addr    = '0;
    mem_data    = '0;
    mem_byte_en = '0;
    if (issue_wr) begin
      mem_addr    = head.addr;
      mem_data    = head.data;
      mem_byte_en = head.byte_en;
    end else if (state == S_RD) begin
      mem_addr = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_addr     <= '0;
      cpu_q       <= '0;
      cpu_q_valid <= 1'b0;
    end else begin
      state       <= state_next;
      cpu_q_valid <= (state == S_RD_WAIT) && mem_q_valid;
      if (state == S_RD_WAIT && mem_q_valid) cpu_q <= mem_q;
      if (rd_acc) rd_addr <= cpu_addr;
    end
  end

  assign fill_level = count;

endmodule

// File: tb/tb_sdram_write_buffer.sv
module tb_sdram_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] cpu_addr = '0;
  logic [15:0] cpu_data = '0;
  logic [1:0]  cpu_byte_en = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_ready;
  logic [15:0] cpu_q;
  logic        cpu_q_valid;
  logic [24:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_byte_en;
  logic        mem_wr;
  logic        mem_rd;
  logic        mem_busy = 1'b0;
  logic [15:0] mem_q = '0;
  logic        mem_q_valid = 1'b0;
  logic [3:0]  fill_level;

  sdram_write_buffer #(
    .ADDR_WIDTH   (25),
    .DATA_WIDTH   (16),
    .DQM_WIDTH    (2),
    .OUTPUT_WIDTH (16),
    .DEPTH        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_byte_en (cpu_byte_en),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .cpu_ready   (cpu_ready),
    .cpu_q       (cpu_q),
    .cpu_q_valid (cpu_q_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_byte_en (mem_byte_en),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_busy    (mem_busy),
    .mem_q       (mem_q),
    .mem_q_valid (mem_q_valid),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } port_txn_t;

  port_txn_t   exp_port[$];
  logic [15:0] exp_rd[$];
  logic [15:0] model [logic [24:0]];
  port_txn_t   mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          prev_mqv = 1'b0;
  int          rsp_cnt = 0;
  logic [24:0] rsp_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
    port_txn_t t;
    t.is_rd = 1'b0; t.addr = a; t.data = d; t.be = be;
    exp_port.push_back(t);
  endtask

  task automatic expect_rd(input logic [24:0] a, input logic [15:0] q);
    port_txn_t t;
    t.is_rd = 1'b1; t.addr = a; t.data = '0; t.be = '0;
    exp_port.push_back(t);
    exp_rd.push_back(q);
  endtask

  // Monitor: compares every accepted port request and every returned read.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (mem_wr === 1'b1 && mem_rd === 1'b1) chk("wr_rd_exclusive", 1, 0);
      if ((mem_wr === 1'b1 || mem_rd === 1'b1) && mem_busy == 1'b0) begin
        if (exp_port.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_port_req: got %s addr 0x%0h, required none",
                   mem_rd ? "rd" : "wr", mem_addr);
        end else begin
          mon_e = exp_port.pop_front();
          chk("port_is_rd", {31'd0, mem_rd}, {31'd0, mon_e.is_rd});
          chk("port_addr", {7'd0, mem_addr}, {7'd0, mon_e.addr});
          chk("port_data", {16'd0, mem_data}, {16'd0, mon_e.data});
          chk("port_be", {30'd0, mem_byte_en}, {30'd0, mon_e.be});
        end
        if (mem_wr === 1'b1) begin
          if (!model.exists(mem_addr)) model[mem_addr] = '0;
          if (mem_byte_en[0]) model[mem_addr][7:0]  = mem_data[7:0];
          if (mem_byte_en[1]) model[mem_addr][15:8] = mem_data[15:8];
        end else begin
          rsp_addr = mem_addr;
          rsp_cnt  = 2;
        end
      end
      if (cpu_q_valid === 1'b1) begin
        chk("cpu_q_latency", {31'd0, prev_mqv}, 32'd1);
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_cpu_q: got 0x%0h, required no read data", cpu_q);
        end else begin
          chk("cpu_q", {16'd0, cpu_q}, {16'd0, exp_rd.pop_front()});
        end
      end
      prev_mqv = mem_q_valid;
    end
  end

  // Port read-data model: answers two cycles after a read is accepted.
  always @(negedge clk) begin
    mem_q_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_q       = model.exists(rsp_addr) ? model[rsp_addr] : 16'h0;
        mem_q_valid = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 200 && cpu_ready !== 1'b1; k++) begin
      @(negedge clk);
      #1;
    end
    if (cpu_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got cpu_ready=%b, required 1", cpu_ready);
    end
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    cpu_addr = a; cpu_data = d; cpu_byte_en = be; cpu_wr = 1'b1; cpu_rd = 1'b0;
    #1;
    wait_ready();
    @(posedge clk);
  endtask

  task automatic rd(input logic [24:0] a);
    @(negedge clk);
    cpu_addr = a; cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    wait_ready();
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      #3;
      done = exp_port.size() == 0 && exp_rd.size() == 0 && rsp_cnt == 0 &&
             fill_level == 4'd0 && mem_wr === 1'b0 && mem_rd === 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: got %0d port / %0d read expectations pending, fill=%0d, required 0",
               name, exp_port.size(), exp_rd.size(), fill_level);
    end
    chk({name, "_fill_end"}, {28'd0, fill_level}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_fill", {28'd0, fill_level}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("post_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("post_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("post_rst_mem_addr", {7'd0, mem_addr}, 32'd0);
    chk("post_rst_cpu_q", {16'd0, cpu_q}, 32'd0);
    chk("post_rst_q_valid", {31'd0, cpu_q_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);

    // 1: three back-to-back writes, one-cycle issue latency
    expect_wr(25'h10, 16'h1111, 2'b11);
    expect_wr(25'h11, 16'h2222, 2'b11);
    expect_wr(25'h12, 16'h3333, 2'b11);
    @(negedge clk);
    cpu_addr = 25'h10; cpu_data = 16'h1111; cpu_byte_en = 2'b11; cpu_wr = 1'b1;
    #1 chk("t1_mem_wr_c0", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    cpu_addr = 25'h11; cpu_data = 16'h2222;
    #1 chk("t1_mem_wr_c1", {31'd0, mem_wr}, 32'd1);
    @(negedge clk);
    cpu_addr = 25'h12; cpu_data = 16'h3333;
    #1 chk("t1_mem_wr_c2", {31'd0, mem_wr}, 32'd1);
    @(negedge clk);
    cpu_wr = 1'b0;
    #1 chk("t1_mem_wr_c3", {31'd0, mem_wr}, 32'd1);
    @(negedge clk);
    #1 chk("t1_mem_wr_c4", {31'd0, mem_wr}, 32'd0);
    drain("t1");

    // 2: fill to DEPTH under backpressure, ninth write waits
    @(negedge clk);
    mem_busy = 1'b1;
    for (int i = 0; i < 9; i++) expect_wr(25'h100 + 25'(i), 16'hA000 + 16'(i), 2'b11);
    for (int i = 0; i < 8; i++) wr(25'h100 + 25'(i), 16'hA000 + 16'(i), 2'b11);
    @(negedge clk);
    cpu_addr = 25'h108; cpu_data = 16'hA008; cpu_byte_en = 2'b11; cpu_wr = 1'b1;
    #1;
    chk("t2_ready_full", {31'd0, cpu_ready}, 32'd0);
    chk("t2_fill_full", {28'd0, fill_level}, 32'd8);
    mem_busy = 1'b0;
    wait_ready();
    @(posedge clk);
    go_idle();
    drain("t2");

    // 3: merge into tail entry
    mem_busy = 1'b1;
    expect_wr(25'h1F, 16'h1F1F, 2'b11);
    expect_wr(25'h20, 16'hBBAA, 2'b11);
    wr(25'h1F, 16'h1F1F, 2'b11);
    wr(25'h20, 16'h00AA, 2'b01);
    wr(25'h20, 16'hBB00, 2'b10);
    go_idle();
    #1 chk("t3_fill_merged", {28'd0, fill_level}, 32'd2);
    mem_busy = 1'b0;
    drain("t3");

    // 3b: same address as the presented head is queued, not merged
    mem_busy = 1'b1;
    expect_wr(25'h50, 16'h1111, 2'b11);
    expect_wr(25'h50, 16'h2222, 2'b11);
    wr(25'h50, 16'h1111, 2'b11);
    wr(25'h50, 16'h2222, 2'b11);
    go_idle();
    #1 chk("t3b_fill_nomerge", {28'd0, fill_level}, 32'd2);
    mem_busy = 1'b0;
    drain("t3b");

    // 4: read after write to the same address
    expect_wr(25'h30, 16'h1234, 2'b11);
    expect_rd(25'h30, 16'h1234);
    wr(25'h30, 16'h1234, 2'b11);
    rd(25'h30);
    @(negedge clk);
    cpu_rd = 1'b0;
    #1;
    chk("t4_ready_rd", {31'd0, cpu_ready}, 32'd0);
    chk("t4_mem_rd", {31'd0, mem_rd}, 32'd1);
    drain("t4");

    // 5: reset with queued writes discards them
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) wr(25'h60 + 25'(i), 16'hC000 + 16'(i), 2'b11);
    go_idle();
    #1 chk("t5_fill_queued", {28'd0, fill_level}, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("t5_ready_in_rst", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_mem_wr_after", {31'd0, mem_wr}, 32'd0);
    chk("t5_fill_after", {28'd0, fill_level}, 32'd0);
    mem_busy = 1'b0;
    repeat (10) @(negedge clk);

    // 6: simultaneous wr and rd behaves as a write only
    expect_wr(25'h40, 16'h5555, 2'b11);
    @(negedge clk);
    cpu_addr = 25'h40; cpu_data = 16'h5555; cpu_byte_en = 2'b11;
    cpu_wr = 1'b1; cpu_rd = 1'b1;
    #1;
    wait_ready();
    @(posedge clk);
    go_idle();
    drain("t6");
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
